// File: rtl/rgb_pack_pkg.sv
// Shared types and sizes for the RGB888 to 128-bit AXI-Stream packer.
package rgb_pack_pkg;

  localparam int unsigned PIX_PER_BEAT   = 4;
  localparam int unsigned BYTES_PER_BEAT = 12;
  localparam int unsigned OUT_BYTES      = 16;
  localparam int unsigned BEAT_W         = BYTES_PER_BEAT * 8;
  localparam int unsigned WORD_W         = OUT_BYTES * 8;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned TOTAL_W        = CNT_W + 1;
  localparam int unsigned WORD_CNT_W     = 32;
  localparam int unsigned LINE_CNT_W     = 16;

  typedef enum logic {
    PACK_PAD32 = 1'b0,
    PACK_RGB24 = 1'b1
  } pack_mode_e;

  typedef enum logic [1:0] {
    IDLE_LINE = 2'd0,
    IN_LINE   = 2'd1,
    FLUSH     = 2'd2
  } line_state_e;

  typedef struct packed {
    logic [WORD_W-1:0]    tdata;
    logic [OUT_BYTES-1:0] tkeep;
    logic                 tlast;
  } out_word_t;

  // Byte-valid mask with the lowest nbytes bits set.
  function automatic logic [OUT_BYTES-1:0] keep_mask(input logic [TOTAL_W-1:0] nbytes);
    keep_mask = '0;
    for (int i = 0; i < int'(OUT_BYTES); i++) begin
      if (i < int'(nbytes)) keep_mask[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/rgb_pack_residual.sv
// Packed-mode residual store: merges held bytes with a new 12-byte beat
// and keeps whatever does not fit in the emitted 16-byte word.
module rgb_pack_residual
  import rgb_pack_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [BEAT_W-1:0]   beat_i,
  input  logic                push_i,
  input  logic                last_i,
  input  logic                flush_i,
  output logic [WORD_W-1:0]   merged_c_o,
  output logic [WORD_W-1:0]   res_word_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [TOTAL_W-1:0]  total_c_o
);

  localparam int unsigned RES_W   = BEAT_W;
  localparam int unsigned MERGE_W = 2 * BEAT_W;

  logic [RES_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MERGE_W-1:0] merged;
  logic [TOTAL_W-1:0] total;

  // Bytes above cnt_q are always zero, so the new beat can simply be OR-ed in.
  always_comb begin
    total  = TOTAL_W'(cnt_q) + TOTAL_W'(BYTES_PER_BEAT);
    merged = MERGE_W'(res_q) | (MERGE_W'(beat_i) << {cnt_q, 3'b000});
    res_d  = res_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      res_d = '0;
      cnt_d = '0;
    end else if (push_i) begin
      if (last_i && (total <= TOTAL_W'(OUT_BYTES))) begin
        res_d = '0;
        cnt_d = '0;
      end else if (total >= TOTAL_W'(OUT_BYTES)) begin
        res_d = RES_W'(merged[MERGE_W-1:WORD_W]);
        cnt_d = CNT_W'(total - TOTAL_W'(OUT_BYTES));
      end else begin
        res_d = merged[RES_W-1:0];
        cnt_d = CNT_W'(total);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  assign merged_c_o = merged[WORD_W-1:0];
  assign res_word_o = WORD_W'(res_q);
  assign cnt_o      = cnt_q;
  assign total_c_o  = total;

endmodule

// File: rtl/rgb_pack_axis.sv
// Streaming RGB888 to 128-bit AXI-Stream packer, padded 32bpp or packed 24bpp.
// Optional word/line counters when RGB_PACK_CNT_EN is defined.
module rgb_pack_axis
  import rgb_pack_pkg::*;
#(
  parameter int unsigned PARALLEL_NUM = 4,
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter int unsigned OUT_WIDTH    = 128
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mode,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [PARALLEL_NUM*8-1:0] i_rgb_r,
  input  logic [PARALLEL_NUM*8-1:0] i_rgb_g,
  input  logic [PARALLEL_NUM*8-1:0] i_rgb_b,
  input  logic                      i_last,
  output logic                      o_tvalid,
  input  logic                      i_tready,
  output logic [OUT_WIDTH-1:0]      o_tdata,
  output logic [OUT_WIDTH/8-1:0]    o_tkeep,
`ifdef RGB_PACK_CNT_EN
  output logic [WORD_CNT_W-1:0]     o_word_cnt,
  output logic [LINE_CNT_W-1:0]     o_line_cnt,
`endif
  output logic                      o_tlast
);

  if (PARALLEL_NUM != PIX_PER_BEAT || OUT_WIDTH != WORD_W) begin : g_param_check
    $error("rgb_pack_axis: only PARALLEL_NUM=4 and OUT_WIDTH=128 are supported");
  end

  line_state_e        state_q, state_d;
  pack_mode_e         mode_q, mode_d, line_mode;
  out_word_t          out_q, out_d;
  logic               tvalid_q, tvalid_d;
  logic               slot_free, accept, drain, push, flush;
  logic [BEAT_W-1:0]  beat_bytes;
  logic [WORD_W-1:0]  pad_word, merged, res_word;
  logic [CNT_W-1:0]   res_cnt;
  logic [TOTAL_W-1:0] total;

  // Byte order per pixel is B, G, R from the low address up.
  always_comb begin
    beat_bytes = '0;
    pad_word   = '0;
    for (int k = 0; k < int'(PARALLEL_NUM); k++) begin
      beat_bytes[24*k +: 24] = {i_rgb_r[8*k +: 8], i_rgb_g[8*k +: 8], i_rgb_b[8*k +: 8]};
      pad_word[32*k +: 32]   = {PAD_BYTE, i_rgb_r[8*k +: 8], i_rgb_g[8*k +: 8], i_rgb_b[8*k +: 8]};
    end
  end

  assign slot_free = !tvalid_q || i_tready;
  assign o_ready   = (state_q != FLUSH) && slot_free;
  assign accept    = i_valid && o_ready;
  assign drain     = tvalid_q && i_tready;
  assign line_mode = (state_q == IDLE_LINE) ? pack_mode_e'(i_mode) : mode_q;

  rgb_pack_residual u_residual (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .beat_i     (beat_bytes),
    .push_i     (push),
    .last_i     (i_last),
    .flush_i    (flush),
    .merged_c_o (merged),
    .res_word_o (res_word),
    .cnt_o      (res_cnt),
    .total_c_o  (total)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    out_d    = out_q;
    tvalid_d = tvalid_q;
    push     = 1'b0;
    flush    = 1'b0;
    if (drain) tvalid_d = 1'b0;
    if (state_q == FLUSH) begin
      if (slot_free) begin
        out_d.tdata = res_word;
        out_d.tkeep = keep_mask(TOTAL_W'(res_cnt));
        out_d.tlast = 1'b1;
        tvalid_d    = 1'b1;
        flush       = 1'b1;
        state_d     = IDLE_LINE;
      end
    end else if (accept) begin
      if (state_q == IDLE_LINE) mode_d = line_mode;
      state_d = i_last ? IDLE_LINE : IN_LINE;
      if (line_mode == PACK_PAD32) begin
        out_d.tdata = pad_word;
        out_d.tkeep = {OUT_BYTES{1'b1}};
        out_d.tlast = i_last;
        tvalid_d    = 1'b1;
      end else begin
        push = 1'b1;
        if (total >= TOTAL_W'(OUT_BYTES)) begin
          out_d.tdata = merged;
          out_d.tkeep = {OUT_BYTES{1'b1}};
          out_d.tlast = i_last && (total == TOTAL_W'(OUT_BYTES));
          tvalid_d    = 1'b1;
          if (i_last && (total > TOTAL_W'(OUT_BYTES))) state_d = FLUSH;
        end else if (i_last) begin
          out_d.tdata = merged;
          out_d.tkeep = keep_mask(total);
          out_d.tlast = 1'b1;
          tvalid_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE_LINE;
      mode_q   <= PACK_PAD32;
      out_q    <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      out_q    <= out_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign o_tvalid = tvalid_q;
  assign o_tdata  = out_q.tdata;
  assign o_tkeep  = out_q.tkeep;
  assign o_tlast  = out_q.tlast;

`ifdef RGB_PACK_CNT_EN
  logic [WORD_CNT_W-1:0] word_cnt_q;
  logic [LINE_CNT_W-1:0] line_cnt_q;

  // Counts words as they leave the output register; both wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_cnt_q <= '0;
      line_cnt_q <= '0;
    end else if (drain) begin
      word_cnt_q <= word_cnt_q + WORD_CNT_W'(1);
      if (out_q.tlast) line_cnt_q <= line_cnt_q + LINE_CNT_W'(1);
    end
  end

  assign o_word_cnt = word_cnt_q;
  assign o_line_cnt = line_cnt_q;
`endif

endmodule

// File: tb/tb_rgb_pack_axis.sv
// Self-checking bench for rgb_pack_axis: a byte-stream reference model builds
// the expected words of each line; a monitor collects words actually accepted.
module tb_rgb_pack_axis;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_mode = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [31:0]  i_rgb_r = '0, i_rgb_g = '0, i_rgb_b = '0;
  logic         i_last = 1'b0;
  logic         o_tvalid;
  logic         i_tready = 1'b1;
  logic [127:0] o_tdata;
  logic [15:0]  o_tkeep;
  logic         o_tlast;
`ifdef RGB_PACK_CNT_EN
  logic [31:0]  o_word_cnt;
  logic [15:0]  o_line_cnt;
`endif

  rgb_pack_axis dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_mode   (i_mode),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_rgb_r  (i_rgb_r),
    .i_rgb_g  (i_rgb_g),
    .i_rgb_b  (i_rgb_b),
    .i_last   (i_last),
    .o_tvalid (o_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tkeep  (o_tkeep),
`ifdef RGB_PACK_CNT_EN
    .o_word_cnt (o_word_cnt),
    .o_line_cnt (o_line_cnt),
`endif
    .o_tlast  (o_tlast)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } word_t;

  word_t got_q[$];
  word_t exp_q[$];
  int    checks = 0;
  int    passed = 0;
  int    tready_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 stalled
  int    stab_viol = 0;
  word_t prev_w;
  bit    prev_stall = 1'b0;

  always @(posedge i_clk) begin
    #1;
    case (tready_mode)
      0:       i_tready = 1'b1;
      1:       i_tready = ~i_tready;
      2:       i_tready = 1'($urandom_range(0, 1));
      default: i_tready = 1'b0;
    endcase
  end

  // Collect accepted words and note any change of a stalled word.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (o_tvalid !== 1'b1 || {o_tdata, o_tkeep, o_tlast} !== prev_w))
        stab_viol++;
      if (o_tvalid === 1'b1 && i_tready === 1'b1) got_q.push_back({o_tdata, o_tkeep, o_tlast});
      prev_stall = (o_tvalid === 1'b1) && (i_tready === 1'b0);
      prev_w     = {o_tdata, o_tkeep, o_tlast};
    end
  end

  task automatic drive_beat(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                            input logic last, input logic mode);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    i_valid = 1'b1;
    i_rgb_r = r;
    i_rgb_g = g;
    i_rgb_b = b;
    i_last  = last;
    i_mode  = mode;
    while (!done) begin
      @(negedge i_clk);
      done = (o_ready === 1'b1);
      @(posedge i_clk);
      #1;
      n++;
      if (!done && n > 2000) begin
        checks++;
        $display("FAIL drive_timeout: o_ready=%b after %0d cycles, want 1", o_ready, n);
        done = 1'b1;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // pat: 0 random, 1 R=G=B=pixel index, 2 R=A0+k G=B0+k B=C0+k
  task automatic send_line(input int nb, input int pat, input logic mode0, input bit flip,
                           input bit do_last);
    logic [7:0]  bq[$];
    logic [31:0] r, g, b;
    logic        m;
    word_t       w;
    int          n, cnt;
    r = '0; g = '0; b = '0;
    for (int bt = 0; bt < nb; bt++) begin
      for (int k = 0; k < 4; k++) begin
        n = bt * 4 + k;
        case (pat)
          1: begin
            r[8*k +: 8] = 8'(n); g[8*k +: 8] = 8'(n); b[8*k +: 8] = 8'(n);
          end
          2: begin
            r[8*k +: 8] = 8'(160 + k); g[8*k +: 8] = 8'(176 + k); b[8*k +: 8] = 8'(192 + k);
          end
          default: begin
            r[8*k +: 8] = 8'($urandom); g[8*k +: 8] = 8'($urandom); b[8*k +: 8] = 8'($urandom);
          end
        endcase
      end
      m = (flip && bt > 0) ? ~mode0 : mode0;
      drive_beat(r, g, b, do_last && (bt == nb - 1), m);
      if (!mode0) begin
        w.d = '0;
        for (int k = 0; k < 4; k++) w.d[32*k +: 32] = {8'h00, r[8*k +: 8], g[8*k +: 8], b[8*k +: 8]};
        w.k = 16'hFFFF;
        w.l = do_last && (bt == nb - 1);
        exp_q.push_back(w);
      end else begin
        for (int k = 0; k < 4; k++) begin
          bq.push_back(b[8*k +: 8]);
          bq.push_back(g[8*k +: 8]);
          bq.push_back(r[8*k +: 8]);
        end
      end
    end
    if (mode0 && do_last) begin
      while (bq.size() > 0) begin
        cnt = (bq.size() > 16) ? 16 : bq.size();
        w.d = '0;
        w.k = '0;
        for (int i = 0; i < cnt; i++) begin
          w.d[8*i +: 8] = bq.pop_front();
          w.k[i] = 1'b1;
        end
        w.l = (bq.size() == 0);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 4000) begin
      @(posedge i_clk);
      n++;
    end
    repeat (6) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", o_tvalid); else passed++;
    checks++; if (o_tdata !== '0) $display("FAIL reset_tdata: got %h want 0", o_tdata); else passed++;
    checks++; if (o_tkeep !== 16'h0) $display("FAIL reset_tkeep: got %h want 0", o_tkeep); else passed++;
    checks++; if (o_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", o_tlast); else passed++;
    checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready); else passed++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_padded();
    send_line(1, 2, 1'b0, 1'b0, 1'b1);
    checks++; if (o_tvalid !== 1'b1) $display("FAIL pad_latency: tvalid got %b want 1", o_tvalid); else passed++;
    wait_out();
    checks++;
    if (got_q.size() != 1) $display("FAIL pad_count: got %0d words want 1", got_q.size());
    else begin
      passed++;
      checks++;
      if (got_q[0].d !== 128'h00A3B3C3_00A2B2C2_00A1B1C1_00A0B0C0)
        $display("FAIL pad_tdata: got %h want 00a3b3c300a2b2c200a1b1c100a0b0c0", got_q[0].d);
      else passed++;
      checks++;
      if (got_q[0].k !== 16'hFFFF || got_q[0].l !== 1'b1)
        $display("FAIL pad_keep_last: got %h/%b want ffff/1", got_q[0].k, got_q[0].l);
      else passed++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_packed();
    send_line(4, 1, 1'b1, 1'b0, 1'b1);
    wait_out();
    checks++;
    if (got_q.size() != 3) $display("FAIL packed_count: got %0d words want 3", got_q.size());
    else begin
      passed++;
      checks++;
      if (got_q[0].d !== 128'h05040404_03030302_02020101_01000000)
        $display("FAIL packed_word0: got %h want 05040404030303020202010101000000", got_q[0].d);
      else passed++;
      checks++;
      if ({got_q[0].l, got_q[1].l, got_q[2].l} !== 3'b001)
        $display("FAIL packed_tlast: got %b want 001", {got_q[0].l, got_q[1].l, got_q[2].l});
      else passed++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i])
          $display("FAIL packed_word%0d: got %h/%h/%b want %h/%h/%b", i, got_q[i].d, got_q[i].k,
                   got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
        else passed++;
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_partial();
    send_line(1, 0, 1'b1, 1'b0, 1'b1);
    send_line(2, 0, 1'b1, 1'b0, 1'b1);
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", o_ready); else passed++;
    wait_out();
    checks++;
    if (got_q.size() != 3) $display("FAIL partial_count: got %0d words want 3", got_q.size());
    else begin
      passed++;
      checks++;
      if (got_q[0].k !== 16'h0FFF || got_q[0].d[127:96] !== 32'h0)
        $display("FAIL partial_one_beat: got keep %h hi %h want 0fff 00000000", got_q[0].k, got_q[0].d[127:96]);
      else passed++;
      checks++;
      if (got_q[1].k !== 16'hFFFF || got_q[2].k !== 16'h00FF)
        $display("FAIL partial_two_beat_keep: got %h,%h want ffff,00ff", got_q[1].k, got_q[2].k);
      else passed++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i])
          $display("FAIL partial_word%0d: got %h/%h/%b want %h/%h/%b", i, got_q[i].d, got_q[i].k,
                   got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
        else passed++;
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_mode_flip();
    send_line(5, 0, 1'b1, 1'b1, 1'b1);
    send_line(3, 0, 1'b0, 1'b1, 1'b1);
    send_line(2, 0, 1'b1, 1'b0, 1'b1);
    wait_out();
    checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL flip_count: got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) $display("FAIL flip_word%0d: got none want %h", i, exp_q[i].d);
      else if (got_q[i] !== exp_q[i])
        $display("FAIL flip_word%0d: got %h/%h/%b want %h/%h/%b", i, got_q[i].d, got_q[i].k,
                 got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      else passed++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    stab_viol = 0;
    tready_mode = 1;
    send_line(64, 0, 1'b1, 1'b0, 1'b1);
    wait_out();
    tready_mode = 0;
    checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) $display("FAIL bp_word%0d: got none want %h", i, exp_q[i].d);
      else if (got_q[i] !== exp_q[i])
        $display("FAIL bp_word%0d: got %h/%h/%b want %h/%h/%b", i, got_q[i].d, got_q[i].k,
                 got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      else passed++;
    end
    checks++; if (stab_viol !== 0) $display("FAIL bp_stable: got %0d changes want 0", stab_viol); else passed++;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    stab_viol = 0;
    tready_mode = 2;
    for (int ln = 0; ln < 10; ln++)
      send_line(int'($urandom_range(1, 9)), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    wait_out();
    tready_mode = 0;
    checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) $display("FAIL rand_word%0d: got none want %h", i, exp_q[i].d);
      else if (got_q[i] !== exp_q[i])
        $display("FAIL rand_word%0d: got %h/%h/%b want %h/%h/%b", i, got_q[i].d, got_q[i].k,
                 got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      else passed++;
    end
    checks++; if (stab_viol !== 0) $display("FAIL rand_stable: got %0d changes want 0", stab_viol); else passed++;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    tready_mode = 3;
    send_line(2, 1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    checks++; if (o_tvalid !== 1'b1) $display("FAIL rmid_pending: got %b want 1", o_tvalid); else passed++;
    @(negedge i_clk);
    checks++;
    if (o_tvalid !== 1'b0 || o_tdata !== '0 || o_tkeep !== 16'h0 || o_tlast !== 1'b0)
      $display("FAIL rmid_outputs: got %b/%h/%h/%b want 0/0/0/0", o_tvalid, o_tdata, o_tkeep, o_tlast);
    else passed++;
    tready_mode = 0;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    got_q.delete(); exp_q.delete();
    send_line(1, 1, 1'b1, 1'b0, 1'b1);
    wait_out();
    checks++;
    if (got_q.size() != 1) $display("FAIL rmid_count: got %0d words want 1", got_q.size());
    else begin
      passed++;
      checks++;
      if (got_q[0].d !== 128'h00000000_03030302_02020101_01000000 || got_q[0].k !== 16'h0FFF || got_q[0] !== exp_q[0])
        $display("FAIL rmid_word0: got %h/%h want 00000000030303020202010101000000/0fff", got_q[0].d, got_q[0].k);
      else passed++;
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef RGB_PACK_CNT_EN
  task automatic test_counters();
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    checks++;
    if (o_word_cnt !== 32'd0 || o_line_cnt !== 16'd0)
      $display("FAIL cnt_reset: got %0d/%0d want 0/0", o_word_cnt, o_line_cnt);
    else passed++;
    for (int ln = 0; ln < 3; ln++) send_line(4, 0, 1'b1, 1'b0, 1'b1);
    wait_out();
    checks++; if (o_word_cnt !== 32'd9) $display("FAIL cnt_words: got %0d want 9", o_word_cnt); else passed++;
    checks++; if (o_line_cnt !== 16'd3) $display("FAIL cnt_lines: got %0d want 3", o_line_cnt); else passed++;
    got_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_padded();
    test_packed();
    test_partial();
    test_mode_flip();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef RGB_PACK_CNT_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
